axi4_lite_master: RTL and testbench
===================================

AXI4_LITE_MASTER -- requirements
Module: axi4_lite_master

Interface
REQ-001 Parameter ADDR_WIDTH, default 4: AXI address width in bits.
REQ-002 Parameter DATA_WIDTH, default 32: AXI data width in bits.
REQ-003 ACLK  in  1  clock; all logic on rising edge.
REQ-004 ARESETn  in  1  reset; asynchronous, active-low.
REQ-005 cmd_valid  in  1  user request present.
REQ-006 cmd_ready  out  1  block accepts request this cycle.
REQ-007 cmd_write  in  1  1 = write, 0 = read.
REQ-008 cmd_addr  in  ADDR_WIDTH  target byte address.
REQ-009 cmd_wdata  in  DATA_WIDTH  write data.
REQ-010 rsp_valid  out  1  one-cycle completion pulse.
REQ-011 rsp_write  out  1  completed transfer was a write.
REQ-012 rsp_rdata  out  DATA_WIDTH  read data, valid with rsp_valid.
REQ-013 rsp_resp  out  2  BRESP or RRESP of the completed transfer.
REQ-014 busy  out  1  transfer in progress (state != IDLE).
REQ-015 AWADDR/AWVALID out, AWREADY in: write address channel, ADDR_WIDTH/1/1.
REQ-016 WDATA/WVALID out, WREADY in: write data channel, DATA_WIDTH/1/1.
REQ-017 BRESP/BVALID in, BREADY out: write response channel, 2/1/1.
REQ-018 ARADDR/ARVALID out, ARREADY in: read address channel, ADDR_WIDTH/1/1.
REQ-019 RDATA/RRESP/RVALID in, RREADY out: read data channel, DATA_WIDTH/2/1.

Function
REQ-020 FSM states SHALL be IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP; one transfer outstanding at a time.
REQ-021 cmd_ready SHALL be 1 only in IDLE; request accepted on edge where cmd_valid & cmd_ready; addr/wdata/write registered at that edge.
REQ-022 Accepted write -> WR_REQ; AWVALID and WVALID both 1 from the next cycle; AWADDR = captured addr, WDATA = captured data.
REQ-023 In WR_REQ, AW and W handshakes SHALL be tracked independently (aw_done, w_done); each VALID deasserts the cycle after its own handshake; both handshakes in the same cycle SHALL be legal.
REQ-024 WR_REQ -> WR_RESP once both handshakes complete; BREADY = 1 throughout WR_RESP only.
REQ-025 In WR_RESP, on BVALID & BREADY: capture BRESP, pulse rsp_valid=1, rsp_write=1 next cycle, return to IDLE.
REQ-026 Accepted read -> RD_REQ; ARVALID = 1, ARADDR = captured addr from next cycle until ARREADY; then RD_RESP.
REQ-027 RREADY = 1 throughout RD_RESP only; on RVALID & RREADY capture RDATA and RRESP, pulse rsp_valid=1, rsp_write=0 next cycle, return to IDLE.
REQ-028 Any VALID, once asserted, SHALL stay 1 with stable payload until its handshake; no VALID SHALL depend combinationally on its READY.
REQ-029 All AXI outputs and rsp_* SHALL be registered (no combinational path from AXI inputs).
REQ-030 rsp_rdata and rsp_resp SHALL hold their last captured value until the next completion; rsp_rdata unchanged by writes.
REQ-031 Minimum latency with slave always ready: cmd accept at edge N, AW/W handshake edge N+1, BVALID sampled edge N+2, rsp_valid high in cycle after N+2; reads identical with AR/R.
REQ-032 cmd_valid outside IDLE SHALL be ignored (not queued); rsp_valid and cmd_ready SHALL NOT be 1 in the same cycle.
REQ-033 Non-OKAY responses (SLVERR/DECERR) SHALL be passed to rsp_resp unchanged; no retry.
REQ-034 BVALID or RVALID arriving in a state other than WR_RESP/RD_RESP SHALL be ignored (READY=0).

Reset
REQ-035 On ARESETn=0, immediately: state IDLE, AWVALID=WVALID=ARVALID=0, BREADY=RREADY=0, rsp_valid=0, busy=0, rsp_rdata=0, rsp_resp=0, AWADDR=ARADDR=0, WDATA=0.
REQ-036 Reset mid-transfer SHALL abort the transfer with no rsp_valid pulse; cmd_ready=1 on first cycle after release.

Verification
REQ-037 Write addr 0x4 data 0xDEADBEEF, slave ready all cycles -> one AW and one W handshake, AWADDR=0x4, WDATA=0xDEADBEEF, rsp_valid pulse with rsp_write=1, rsp_resp=00, per REQ-031 timing.
REQ-038 Read addr 0x4 after REQ-037 against register-file slave -> ARADDR=0x4, rsp_rdata=0xDEADBEEF, rsp_write=0, rsp_resp=00.
REQ-039 Write with AWREADY delayed 3 cycles, WREADY immediate -> WVALID drops after 1 cycle, AWVALID held 4 cycles with stable AWADDR, exactly one B handshake.
REQ-040 Read with ARREADY delayed 2 cycles and RVALID delayed 5 cycles, RRESP=10 -> ARVALID/ARADDR stable until handshake, rsp_resp=10, rsp_valid high exactly one cycle.
REQ-041 cmd_valid held high for 4 back-to-back writes to 0x0,0x4,0x8,0xC -> four transfers in order, cmd_ready only in IDLE, four rsp_valid pulses.
REQ-042 ARESETn pulsed low while in WR_RESP -> all VALID/READY outputs 0 asynchronously, no rsp_valid, next write completes normally.

Source files
------------

// File: rtl/axi4_lite_master.sv
// rtl/axi4_lite_master.sv - single-outstanding AXI4-Lite master driven by a simple cmd/rsp port
module axi4_lite_master #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic                  rsp_write,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] AWADDR,
  output logic                  AWVALID,
  input  logic                  AWREADY,
  output logic [DATA_WIDTH-1:0] WDATA,
  output logic                  WVALID,
  input  logic                  WREADY,
  input  logic [1:0]            BRESP,
  input  logic                  BVALID,
  output logic                  BREADY,
  output logic [ADDR_WIDTH-1:0] ARADDR,
  output logic                  ARVALID,
  input  logic                  ARREADY,
  input  logic [DATA_WIDTH-1:0] RDATA,
  input  logic [1:0]            RRESP,
  input  logic                  RVALID,
  output logic                  RREADY
);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP} state_t;

  state_t state;
  logic   aw_done;
  logic   w_done;
  logic   aw_hs;
  logic   w_hs;

  assign aw_hs = AWVALID & AWREADY;
  assign w_hs  = WVALID & WREADY;
  assign busy  = (state != IDLE);
  // Held off during the completion pulse so a new request never overlaps rsp_valid.
  assign cmd_ready = (state == IDLE) & ~rsp_valid;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state     <= IDLE;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      AWADDR    <= '0;
      AWVALID   <= 1'b0;
      WDATA     <= '0;
      WVALID    <= 1'b0;
      BREADY    <= 1'b0;
      ARADDR    <= '0;
      ARVALID   <= 1'b0;
      RREADY    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= 2'b00;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            if (cmd_write) begin
              AWADDR  <= cmd_addr;
              WDATA   <= cmd_wdata;
              AWVALID <= 1'b1;
              WVALID  <= 1'b1;
              aw_done <= 1'b0;
              w_done  <= 1'b0;
              state   <= WR_REQ;
            end else begin
              ARADDR  <= cmd_addr;
              ARVALID <= 1'b1;
              state   <= RD_REQ;
            end
          end
        end
        WR_REQ: begin
          if (aw_hs) begin
            AWVALID <= 1'b0;
            aw_done <= 1'b1;
          end
          if (w_hs) begin
            WVALID <= 1'b0;
            w_done <= 1'b1;
          end
          // AW and W may complete in either order or together.
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            BREADY <= 1'b1;
            state  <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (BVALID && BREADY) begin
            BREADY    <= 1'b0;
            rsp_resp  <= BRESP;
            rsp_write <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= IDLE;
          end
        end
        RD_REQ: begin
          if (ARVALID && ARREADY) begin
            ARVALID <= 1'b0;
            RREADY  <= 1'b1;
            state   <= RD_RESP;
          end
        end
        RD_RESP: begin
          if (RVALID && RREADY) begin
            RREADY    <= 1'b0;
            rsp_rdata <= RDATA;
            rsp_resp  <= RRESP;
            rsp_write <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_lite_master.sv
// tb/tb_axi4_lite_master.sv - scoreboard bench for axi4_lite_master against a register-file slave
module tb_axi4_lite_master;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [3:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_write, busy;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [3:0]  AWADDR, ARADDR;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic [31:0] WDATA, RDATA;
  logic [1:0]  BRESP, RRESP;

  always #5 ACLK = ~ACLK;

  axi4_lite_master #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .busy(busy),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
  );

  // Register-file slave with programmable per-channel delays.
  int          aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
  logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  logic        aw_got, w_got, ar_got;
  logic [3:0]  aw_q, ar_q;
  logic [31:0] w_q;
  logic [31:0] mem [4];
  int          cyc = 0;

  assign AWREADY = AWVALID && (aw_cnt >= aw_delay);
  assign WREADY  = WVALID && (w_cnt >= w_delay);
  assign BVALID  = aw_got && w_got && (b_cnt >= b_delay);
  assign BRESP   = bresp_cfg;
  assign ARREADY = ARVALID && (ar_cnt >= ar_delay);
  assign RVALID  = ar_got && (r_cnt >= r_delay);
  assign RDATA   = mem[ar_q[3:2]];
  assign RRESP   = rresp_cfg;

  always @(posedge ACLK) cyc <= cyc + 1;

  always @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0;
      aw_q <= '0; w_q <= '0; ar_q <= '0;
    end else begin
      aw_cnt <= (AWVALID && !AWREADY) ? aw_cnt + 1 : 0;
      w_cnt  <= (WVALID && !WREADY) ? w_cnt + 1 : 0;
      ar_cnt <= (ARVALID && !ARREADY) ? ar_cnt + 1 : 0;
      if (AWVALID && AWREADY) begin aw_got <= 1'b1; aw_q <= AWADDR; end
      if (WVALID && WREADY) begin w_got <= 1'b1; w_q <= WDATA; end
      if (aw_got && w_got && !BVALID) b_cnt <= b_cnt + 1;
      if (BVALID && BREADY) begin
        aw_got <= 1'b0; w_got <= 1'b0; b_cnt <= 0;
        mem[aw_q[3:2]] <= w_q;
      end
      if (ARVALID && ARREADY) begin ar_got <= 1'b1; ar_q <= ARADDR; end
      if (ar_got && !RVALID) r_cnt <= r_cnt + 1;
      if (RVALID && RREADY) begin ar_got <= 1'b0; r_cnt <= 0; end
    end
  end

  typedef struct {
    logic        w;
    logic [31:0] rdata;
    logic [1:0]  resp;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t        sb[$];
  logic [3:0]  exp_aw[$], exp_ar[$];
  logic [31:0] exp_w[$];
  logic [31:0] model_mem [4];
  logic [31:0] model_last = 32'h0;

  int vectors = 0, miscompares = 0;
  int aw_hi = 0, w_hi = 0, ar_hi = 0, b_hs = 0, rsp_n = 0;
  logic p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_rspv;
  logic [3:0]  p_awaddr, p_araddr;
  logic [31:0] p_wdata;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic monitor_step();
    exp_t e;
    if (p_awv === 1'b1 && p_awr === 1'b0) begin
      check("awvalid_hold", AWVALID, 1);
      check("awaddr_hold", AWADDR, p_awaddr);
    end
    if (p_wv === 1'b1 && p_wr === 1'b0) begin
      check("wvalid_hold", WVALID, 1);
      check("wdata_hold", WDATA, p_wdata);
    end
    if (p_arv === 1'b1 && p_arr === 1'b0) begin
      check("arvalid_hold", ARVALID, 1);
      check("araddr_hold", ARADDR, p_araddr);
    end
    if (AWVALID) aw_hi++;
    if (WVALID) w_hi++;
    if (ARVALID) ar_hi++;
    if (AWVALID && AWREADY) begin
      if (exp_aw.size() == 0) check("aw_unexpected", 1, 0);
      else check("awaddr", AWADDR, exp_aw.pop_front());
    end
    if (WVALID && WREADY) begin
      if (exp_w.size() == 0) check("w_unexpected", 1, 0);
      else check("wdata", WDATA, exp_w.pop_front());
    end
    if (ARVALID && ARREADY) begin
      if (exp_ar.size() == 0) check("ar_unexpected", 1, 0);
      else check("araddr", ARADDR, exp_ar.pop_front());
    end
    if (BVALID && BREADY) b_hs++;
    if (cmd_ready) check("ready_only_idle", busy, 0);
    if (rsp_valid) begin
      rsp_n++;
      check("rsp_vs_ready", cmd_ready, 0);
      check("rsp_pulse", p_rspv, 0);
      if (sb.size() == 0) check("rsp_unexpected", 1, 0);
      else begin
        e = sb.pop_front();
        check("rsp_write", rsp_write, e.w);
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_resp", rsp_resp, e.resp);
        if (e.lat) check("latency", cyc - e.acc, 2);
      end
    end
    p_awv = AWVALID; p_awr = AWREADY; p_awaddr = AWADDR;
    p_wv = WVALID; p_wr = WREADY; p_wdata = WDATA;
    p_arv = ARVALID; p_arr = ARREADY; p_araddr = ARADDR;
    p_rspv = rsp_valid;
  endtask

  task automatic send(input logic w, input logic [3:0] a, input logic [31:0] d,
                      input logic [1:0] resp, input bit lat);
    exp_t e;
    bit acc = 0;
    @(negedge ACLK);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    for (int n = 0; n < 200 && !acc; n++) begin
      if (cmd_ready) begin
        @(posedge ACLK);
        #1;
        acc = 1;
      end else @(negedge ACLK);
    end
    if (!acc) begin
      check("cmd_accept_timeout", 0, 1);
      return;
    end
    e.w = w; e.resp = resp; e.acc = cyc; e.lat = lat;
    if (w) begin
      model_mem[a[3:2]] = d;
      e.rdata = model_last;
      exp_aw.push_back(a);
      exp_w.push_back(d);
    end else begin
      e.rdata = model_mem[a[3:2]];
      model_last = e.rdata;
      exp_ar.push_back(a);
    end
    sb.push_back(e);
  endtask

  task automatic wait_done();
    cmd_valid = 1'b0;
    for (int n = 0; n < 300 && sb.size() != 0; n++) begin
      @(negedge ACLK);
      #1;
    end
    check("rsp_timeout", sb.size(), 0);
  endtask

  logic [31:0] saved;
  int          rsp_base;

  initial begin
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    for (int i = 0; i < 4; i++) begin mem[i] = 32'h0; model_mem[i] = 32'h0; end
    ARESETn = 1'b1;
    #1 ARESETn = 1'b0;
    fork
      forever begin
        @(negedge ACLK);
        monitor_step();
      end
    join_none
    repeat (2) @(negedge ACLK);
    check("reset_ctrl", {AWVALID, WVALID, ARVALID, BREADY, RREADY, rsp_valid, busy}, 0);
    check("reset_rsp", {rsp_rdata, rsp_resp}, 0);
    check("reset_addr", {AWADDR, ARADDR, WDATA}, 0);
    ARESETn = 1'b1;
    #1 check("ready_after_reset", cmd_ready, 1);

    send(1'b1, 4'h4, 32'hDEADBEEF, 2'b00, 1);
    wait_done();
    send(1'b0, 4'h4, 32'h0, 2'b00, 1);
    wait_done();

    aw_delay = 3; aw_hi = 0; w_hi = 0; b_hs = 0;
    send(1'b1, 4'h8, 32'h12345678, 2'b00, 0);
    wait_done();
    check("aw_valid_cycles", aw_hi, 4);
    check("w_valid_cycles", w_hi, 1);
    check("b_handshakes", b_hs, 1);
    aw_delay = 0;

    ar_delay = 2; r_delay = 5; rresp_cfg = 2'b10; ar_hi = 0;
    send(1'b0, 4'h8, 32'h0, 2'b10, 0);
    wait_done();
    check("ar_valid_cycles", ar_hi, 3);
    ar_delay = 0; r_delay = 0; rresp_cfg = 2'b00;

    rsp_base = rsp_n;
    for (int i = 0; i < 4; i++)
      send(1'b1, 4'(i * 4), 32'hA5A50000 + 32'(i), 2'b00, 0);
    wait_done();
    check("b2b_responses", rsp_n - rsp_base, 4);
    send(1'b0, 4'hC, 32'h0, 2'b00, 0);
    wait_done();

    bresp_cfg = 2'b11;
    send(1'b1, 4'h4, 32'hCAFEF00D, 2'b11, 0);
    wait_done();
    bresp_cfg = 2'b00;
    send(1'b0, 4'h4, 32'h0, 2'b00, 0);
    wait_done();

    b_delay = 4;
    saved = model_mem[0];
    send(1'b1, 4'h0, 32'hBAADBAAD, 2'b00, 0);
    cmd_valid = 1'b0;
    for (int n = 0; n < 50 && !BREADY; n++) @(negedge ACLK);
    check("wr_resp_reached", BREADY, 1);
    #2 ARESETn = 1'b0;
    #1 check("abort_outputs", {AWVALID, WVALID, ARVALID, BREADY, RREADY, rsp_valid, busy}, 0);
    void'(sb.pop_back());
    model_mem[0] = saved;
    model_last = 32'h0;
    @(negedge ACLK);
    ARESETn = 1'b1;
    #1 check("ready_after_abort", cmd_ready, 1);
    b_delay = 0;
    send(1'b1, 4'h0, 32'h0F0F0F0F, 2'b00, 0);
    wait_done();
    send(1'b0, 4'h0, 32'h0, 2'b00, 0);
    wait_done();

    repeat (3) @(negedge ACLK);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
